// File: rtl/seq_alu.sv
// Multi-cycle signed ALU: add, subtract, Booth radix-2 multiply (one step per
// clock) and restoring divide (one quotient bit per clock) with a start/busy/done
// handshake. DIV_MODE selects truncating (0) or non-negative-remainder (1) division.
module seq_alu #(
    parameter int unsigned W        = 11,
    parameter int unsigned DIV_MODE = 1
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    input  logic [1:0]     opcode,
    input  logic [W-1:0]   reg_a,
    input  logic [W-1:0]   reg_b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           remain,
    output logic [W-1:0]   remainder,
    output logic           div_zero
);

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    localparam int unsigned CW      = $clog2(W);
    localparam logic [CW-1:0] LastCnt = CW'(W - 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [W-1:0]  One     = W'(1);

    state_e state_q, state_d;

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2*W+1:0] prod_q, prod_d;   // {upper W+1, multiplier W, booth bit}
    logic [W-1:0]   n_q, n_d;         // numerator magnitude, shifted out MSB first
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   r_q, r_d;
    logic [2*W-1:0] result_q, result_d;
    logic           remain_q, remain_d;
    logic [W-1:0]   remainder_q, remainder_d;
    logic           div_zero_q, div_zero_d;

    // Shared datapath terms
    logic [W-1:0]          mag_a_in, mag_b;
    logic [W:0]            a_ext, upper_n;
    logic signed [2*W+1:0] prod_cat, prod_step;
    logic [W:0]            r_sh;
    logic [W-1:0]          r_fix, q_fix;
    logic [2*W-1:0]        q_ext, q_signed;
    logic [2*W-1:0]        sext_a, sext_b;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (opcode == 2'b10) begin
                        state_d = StMul;
                    end else if (opcode == 2'b11 && reg_b != '0) begin
                        state_d = StDiv;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StMul:   if (cnt_q == LastCnt) state_d = StDone;
            StDiv:   if (cnt_q == LastCnt) state_d = StFix;
            StFix:   state_d = StFix == state_q ? StDone : StIdle;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        busy = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
        done = (state_q == StDone);
    end

    // Arithmetic terms for one Booth step, one divide step and the divide fix-up
    always_comb begin
        sext_a   = {{W{reg_a[W-1]}}, reg_a};
        sext_b   = {{W{reg_b[W-1]}}, reg_b};
        mag_a_in = reg_a[W-1] ? ('0 - reg_a) : reg_a;
        mag_b    = b_q[W-1] ? ('0 - b_q) : b_q;

        a_ext   = {a_q[W-1], a_q};
        upper_n = prod_q[2*W+1:W+1];
        if (prod_q[1:0] == 2'b01) begin
            upper_n = upper_n + a_ext;
        end else if (prod_q[1:0] == 2'b10) begin
            upper_n = upper_n - a_ext;
        end
        prod_cat  = {upper_n, prod_q[W:0]};
        prod_step = prod_cat >>> 1;

        // Partial remainder stays below |B| <= 2^(W-1), so the shifted value fits W+1 bits
        r_sh = {r_q, n_q[W-1]};

        r_fix = r_q;
        q_fix = q_q;
        if (DIV_MODE == 1 && a_q[W-1] && r_q != '0) begin
            r_fix = mag_b - r_q;
            q_fix = q_q + One;
        end
        q_ext    = {{W{1'b0}}, q_fix};
        q_signed = (a_q[W-1] ^ b_q[W-1]) ? ('0 - q_ext) : q_ext;
    end

    // Datapath and result next-state
    always_comb begin
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        prod_d      = prod_q;
        n_d         = n_q;
        q_d         = q_q;
        r_d         = r_q;
        result_d    = result_q;
        remain_d    = remain_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d    = reg_a;
                    b_d    = reg_b;
                    cnt_d  = '0;
                    prod_d = {{(W+1){1'b0}}, reg_b, 1'b0};
                    n_d    = mag_a_in;
                    q_d    = '0;
                    r_d    = '0;
                    if (opcode == 2'b00 || opcode == 2'b01) begin
                        result_d    = (opcode == 2'b00) ? (sext_a + sext_b) : (sext_a - sext_b);
                        remain_d    = 1'b0;
                        remainder_d = '0;
                        div_zero_d  = 1'b0;
                    end else if (opcode == 2'b11 && reg_b == '0) begin
                        result_d    = '0;
                        remain_d    = 1'b0;
                        remainder_d = '0;
                        div_zero_d  = 1'b1;
                    end
                end
            end
            StMul: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + CntOne;
                if (cnt_q == LastCnt) begin
                    result_d    = prod_step[2*W:1];
                    remain_d    = 1'b0;
                    remainder_d = '0;
                    div_zero_d  = 1'b0;
                end
            end
            StDiv: begin
                cnt_d = cnt_q + CntOne;
                n_d   = {n_q[W-2:0], 1'b0};
                if (r_sh >= {1'b0, mag_b}) begin
                    r_d = r_sh[W-1:0] - mag_b;
                    q_d = {q_q[W-2:0], 1'b1};
                end else begin
                    r_d = r_sh[W-1:0];
                    q_d = {q_q[W-2:0], 1'b0};
                end
            end
            StFix: begin
                result_d    = q_signed;
                remainder_d = r_fix;
                remain_d    = 1'b1;
                div_zero_d  = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            prod_q      <= '0;
            n_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            result_q    <= '0;
            remain_q    <= 1'b0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            prod_q      <= prod_d;
            n_q         <= n_d;
            q_q         <= q_d;
            r_q         <= r_d;
            result_q    <= result_d;
            remain_q    <= remain_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign result    = result_q;
    assign remain    = remain_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed test-plan cases, abort/ignore/retrigger
// scenarios and randomized operations against an arithmetic reference model.
// Both divide sign conventions are instantiated side by side on shared inputs.
module tb_seq_alu;

    localparam int W = 11;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     opcode = 2'b00;
    logic [W-1:0]   reg_a = '0;
    logic [W-1:0]   reg_b = '0;

    logic           busy1, done1, remain1, dz1;
    logic [2*W-1:0] res1;
    logic [W-1:0]   rem1;
    logic           busy0, done0, remain0, dz0;
    logic [2*W-1:0] res0;
    logic [W-1:0]   rem0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*W-1:0] prev1 = '0;
    logic [2*W-1:0] prev0 = '0;

    seq_alu #(.W(W), .DIV_MODE(1)) dut1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .opcode    (opcode),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .busy      (busy1),
        .done      (done1),
        .result    (res1),
        .remain    (remain1),
        .remainder (rem1),
        .div_zero  (dz1)
    );

    seq_alu #(.W(W), .DIV_MODE(0)) dut0 (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .opcode    (opcode),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .busy      (busy0),
        .done      (done0),
        .result    (res0),
        .remain    (remain0),
        .remainder (rem0),
        .div_zero  (dz0)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; mode 1 uses a Euclidean remainder
    function automatic void model(input int op, input int a, input int b, input int mode,
                                  output int res, output int rem, output int rm, output int dz);
        int mb;
        res = 0; rem = 0; rm = 0; dz = 0;
        mb  = (b < 0) ? -b : b;
        case (op)
            0: res = a + b;
            1: res = a - b;
            2: res = a * b;
            default: begin
                if (b == 0) begin
                    dz = 1;
                end else begin
                    rm = 1;
                    if (mode == 0) begin
                        res = a / b;
                        rem = (a % b < 0) ? -(a % b) : (a % b);
                    end else begin
                        rem = ((a % b) + mb) % mb;
                        res = (a - rem) / b;
                    end
                end
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input int a, input int b, input bit poke);
        int r1, m1, rm1, z1, r0, m0, rm0, z0;
        int lat, bsy, exp_lat;
        bit hold_ok;
        logic [2*W-1:0] e1, e0;
        logic [W-1:0] em1, em0;
        lat = 0; bsy = 0; hold_ok = 1'b1;
        model(int'(op), a, b, 1, r1, m1, rm1, z1);
        model(int'(op), a, b, 0, r0, m0, rm0, z0);
        e1 = r1[2*W-1:0];
        e0 = r0[2*W-1:0];
        em1 = m1[W-1:0];
        em0 = m0[W-1:0];
        if (op == 2'b10) exp_lat = W + 1;
        else if (op == 2'b11 && b != 0) exp_lat = W + 2;
        else exp_lat = 1;

        @(negedge clock);
        start = 1'b1; opcode = op; reg_a = a[W-1:0]; reg_b = b[W-1:0];
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            if (k == 1) begin
                start  = 1'b0;
                opcode = 2'($urandom);
                reg_a  = W'($urandom);
                reg_b  = W'($urandom);
            end
            if (poke && k == 3) begin start = 1'b1; opcode = 2'b00; end
            if (poke && k == 4) start = 1'b0;
            if (done1) begin lat = k; break; end
            if (busy1) bsy++;
            if (res1 !== prev1 || res0 !== prev0) hold_ok = 1'b0;
        end
        if (lat == 0) check_eq("timeout", 64'(0), 64'(1));
        check_eq("latency", 64'(lat), 64'(exp_lat));
        check_eq("busy_cycles", 64'(bsy), 64'(exp_lat - 1));
        check_eq("hold", 64'(hold_ok), 64'(1));
        check_eq("busy_in_done", 64'(busy1), 64'(0));
        check_eq("done_m0", 64'(done0), 64'(1));
        check_eq("result_m1", 64'(res1), 64'(e1));
        check_eq("remainder_m1", 64'(rem1), 64'(em1));
        check_eq("remain_m1", 64'(remain1), 64'(rm1));
        check_eq("div_zero_m1", 64'(dz1), 64'(z1));
        check_eq("result_m0", 64'(res0), 64'(e0));
        check_eq("remainder_m0", 64'(rem0), 64'(em0));
        check_eq("remain_m0", 64'(remain0), 64'(rm0));
        check_eq("div_zero_m0", 64'(dz0), 64'(z0));
        @(negedge clock);
        check_eq("done_pulse", 64'(done1), 64'(0));
        prev1 = e1;
        prev0 = e0;
    endtask

    initial begin
        int dcount;
        logic [W-1:0] ra, rb;
        int a, b;

        #12;
        check_eq("rst_busy", 64'(busy1), 64'(0));
        check_eq("rst_done", 64'(done1), 64'(0));
        check_eq("rst_result", 64'(res1), 64'(0));
        check_eq("rst_flags", 64'({remain1, dz1, rem1}), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;

        run_op(2'b00, 999, -999, 1'b0);
        run_op(2'b01, -999, 999, 1'b0);
        run_op(2'b10, -999, 999, 1'b1);
        run_op(2'b10, -1024, -1024, 1'b0);
        run_op(2'b10, 0, -5, 1'b0);
        run_op(2'b11, 7, -2, 1'b0);
        run_op(2'b11, -1024, -1, 1'b0);
        run_op(2'b11, 5, 0, 1'b0);
        run_op(2'b11, -7, 2, 1'b1);

        // Abort a multiply with reset: everything clears and no done follows
        @(negedge clock);
        start = 1'b1; opcode = 2'b10; reg_a = 11'd123; reg_b = 11'd45;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_eq("abort_busy", 64'(busy1), 64'(0));
        check_eq("abort_result", 64'(res1), 64'(0));
        check_eq("abort_flags", 64'({remain1, dz1, rem1}), 64'(0));
        check_eq("abort_m0", 64'({busy0, done0, res0, remain0, dz0, rem0}), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        dcount = 0;
        repeat (20) begin
            @(negedge clock);
            if (done1 || done0) dcount++;
        end
        check_eq("abort_no_done", 64'(dcount), 64'(0));
        prev1 = '0;
        prev0 = '0;

        // start held high re-triggers an add every two cycles
        start = 1'b1; opcode = 2'b00; reg_a = 11'd3; reg_b = 11'd4;
        dcount = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (done1) dcount++;
        end
        start = 1'b0;
        check_eq("retrigger_count", 64'(dcount), 64'(4));
        check_eq("retrigger_result", 64'(res1), 64'(7));
        prev1 = 22'd7;
        prev0 = 22'd7;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 7) == 0) rb = '0;
            a = $signed(ra);
            b = $signed(rb);
            run_op(2'($urandom), a, b, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
